// File: rtl/pc_sequencer.sv
// Multicycle fetch/next-PC controller: owns the PC, handshakes with instruction memory,
// selects the next PC and sequences interrupt and misaligned-target traps.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] IALIGN_MASK  = 32'h0000_0003
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic        instr_valid,
  input  logic        ex_done,
  input  logic [2:0]  pc_sel,
  input  logic        br_taken,
  input  logic [31:0] jal,
  input  logic [31:0] branch,
  input  logic [31:0] jalr,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        intr,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic        trap_taken,
  output logic [31:0] trap_epc,
  output logic        trap_cause,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    RstS  = 2'd0,
    Fetch = 2'd1,
    Exec  = 2'd2,
    Trap  = 2'd3
  } state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_trap_epc;
  logic        r_trap_cause;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_misaligned;
  logic [2:0]  w_unused_bits;

  // Trap vector is forced word-aligned; jalr bit 0 is always cleared.
  assign w_unused_bits = {mtvec[1:0], jalr[0]};

  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_target = w_pc_plus4;
    case (pc_sel)
      3'd1:    w_target = jal;
      3'd2:    w_target = br_taken ? branch : w_pc_plus4;
      3'd3:    w_target = {jalr[31:1], 1'b0};
      3'd4:    w_target = mepc;
      default: w_target = w_pc_plus4;
    endcase
  end

  assign w_misaligned = |(w_target & IALIGN_MASK);

  // State register plus the PC and trap bookkeeping it sequences.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state      <= RstS;
      r_pc         <= RESET_VECTOR;
      r_trap_epc   <= 32'd0;
      r_trap_cause <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        Exec: begin
          if (ex_done) begin
            if (w_misaligned) begin
              r_trap_epc   <= r_pc;
              r_trap_cause <= 1'b1;
            end else begin
              r_pc <= w_target;
              if (intr) begin
                r_trap_epc   <= w_target;
                r_trap_cause <= 1'b0;
              end
            end
          end
        end
        Trap:    r_pc <= {mtvec[31:2], 2'b00};
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RstS:  w_state_next = Fetch;
      Fetch: if (imem_ack) w_state_next = Exec;
      Exec: begin
        if (ex_done) begin
          w_state_next = (w_misaligned || intr) ? Trap : Fetch;
        end
      end
      Trap:  w_state_next = Fetch;
      default: w_state_next = RstS;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    trap_taken  = 1'b0;
    case (r_state)
      Fetch: begin
        imem_req    = 1'b1;
        instr_valid = imem_ack;
      end
      Trap:    trap_taken = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr  = r_pc;
  assign PC         = r_pc;
  assign PC_plus4   = w_pc_plus4;
  assign trap_epc   = r_trap_epc;
  assign trap_cause = r_trap_cause;
  assign state      = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, sequential flow, branches, traps, stall and wrap.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        instr_valid;
  logic        ex_done;
  logic [2:0]  pc_sel;
  logic        br_taken;
  logic [31:0] jal;
  logic [31:0] branch;
  logic [31:0] jalr;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        intr;
  logic [31:0] PC;
  logic [31:0] PC_plus4;
  logic        trap_taken;
  logic [31:0] trap_epc;
  logic        trap_cause;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  pc_sequencer #(
    .RESET_VECTOR(32'h0000_0000),
    .IALIGN_MASK (32'h0000_0003)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .instr_valid(instr_valid),
    .ex_done    (ex_done),
    .pc_sel     (pc_sel),
    .br_taken   (br_taken),
    .jal        (jal),
    .branch     (branch),
    .jalr       (jalr),
    .mtvec      (mtvec),
    .mepc       (mepc),
    .intr       (intr),
    .PC         (PC),
    .PC_plus4   (PC_plus4),
    .trap_taken (trap_taken),
    .trap_epc   (trap_epc),
    .trap_cause (trap_cause),
    .state      (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Starts in FETCH; acks at once, then ex_done in the first EXEC cycle.
  task automatic run_instr(input logic [2:0] sel, input logic tk, input logic irq);
    imem_ack = 1'b1;
    #1;
    chk("instr_valid_on_ack", {31'd0, instr_valid}, 32'd1);
    tick();
    imem_ack = 1'b0;
    #1;
    chk("state_exec", {30'd0, state}, 32'd2);
    chk("req_low_exec", {31'd0, imem_req}, 32'd0);
    chk("no_valid_exec", {31'd0, instr_valid}, 32'd0);
    pc_sel   = sel;
    br_taken = tk;
    intr     = irq;
    ex_done  = 1'b1;
    tick();
    ex_done  = 1'b0;
    intr     = 1'b0;
    br_taken = 1'b0;
    pc_sel   = 3'd0;
  endtask

  initial begin
    RST_N    = 1'b0;
    imem_ack = 1'b0;
    ex_done  = 1'b0;
    pc_sel   = 3'd0;
    br_taken = 1'b0;
    jal      = 32'd0;
    branch   = 32'd0;
    jalr     = 32'd0;
    mtvec    = 32'd0;
    mepc     = 32'd0;
    intr     = 1'b0;

    // Reset and sequential flow
    tick();
    tick();
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_trap_taken", {31'd0, trap_taken}, 32'd0);
    chk("rst_epc", trap_epc, 32'd0);
    chk("rst_cause", {31'd0, trap_cause}, 32'd0);
    RST_N = 1'b1;
    tick();
    chk("state_fetch0", {30'd0, state}, 32'd1);
    chk("req_fetch0", {31'd0, imem_req}, 32'd1);
    chk("addr0", imem_addr, 32'h0);
    run_instr(3'd0, 1'b0, 1'b0);
    chk("state_back_fetch", {30'd0, state}, 32'd1);
    chk("addr4", imem_addr, 32'h4);
    run_instr(3'd0, 1'b0, 1'b0);
    chk("addr8", imem_addr, 32'h8);
    run_instr(3'd0, 1'b0, 1'b0);
    chk("addrC", imem_addr, 32'hC);
    chk("plus4_C", PC_plus4, 32'h10);

    // Branch / jal / jalr
    jal = 32'h100;
    run_instr(3'd1, 1'b0, 1'b0);
    chk("jal_100", PC, 32'h100);
    branch = 32'h80;
    run_instr(3'd2, 1'b0, 1'b0);
    chk("br_not_taken", PC, 32'h104);
    run_instr(3'd2, 1'b1, 1'b0);
    chk("br_taken", PC, 32'h80);
    jal = 32'h2000;
    run_instr(3'd1, 1'b0, 1'b0);
    chk("jal_2000", PC, 32'h2000);
    jalr = 32'h301;
    run_instr(3'd3, 1'b0, 1'b0);
    chk("jalr_clear_bit0", PC, 32'h300);
    chk("jalr_state_fetch", {30'd0, state}, 32'd1);

    // Misaligned jal target
    jal = 32'h40;
    run_instr(3'd1, 1'b0, 1'b0);
    chk("jal_40", PC, 32'h40);
    jal   = 32'h42;
    mtvec = 32'h1001;
    run_instr(3'd1, 1'b0, 1'b0);
    chk("mis_state_trap", {30'd0, state}, 32'd3);
    chk("mis_pc_held", PC, 32'h40);
    chk("mis_trap_taken", {31'd0, trap_taken}, 32'd1);
    chk("mis_cause", {31'd0, trap_cause}, 32'd1);
    chk("mis_epc", trap_epc, 32'h40);
    tick();
    chk("mis_vector", PC, 32'h1000);
    chk("mis_pulse_end", {31'd0, trap_taken}, 32'd0);
    chk("mis_state_fetch", {30'd0, state}, 32'd1);

    // Interrupt on ex_done, then mret
    jal = 32'h10;
    run_instr(3'd1, 1'b0, 1'b0);
    chk("jal_10", PC, 32'h10);
    mtvec = 32'h800;
    run_instr(3'd0, 1'b0, 1'b1);
    chk("irq_state_trap", {30'd0, state}, 32'd3);
    chk("irq_pc_commit", PC, 32'h14);
    chk("irq_epc", trap_epc, 32'h14);
    chk("irq_cause", {31'd0, trap_cause}, 32'd0);
    chk("irq_trap_taken", {31'd0, trap_taken}, 32'd1);
    tick();
    chk("irq_vector", PC, 32'h800);
    mepc = 32'h14;
    run_instr(3'd4, 1'b0, 1'b0);
    chk("mret", PC, 32'h14);
    chk("epc_held", trap_epc, 32'h14);

    // Stall in FETCH with a pending interrupt that must not be taken
    intr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req", {31'd0, imem_req}, 32'd1);
      chk("stall_pc", PC, 32'h14);
      chk("stall_no_valid", {31'd0, instr_valid}, 32'd0);
      chk("stall_state", {30'd0, state}, 32'd1);
    end
    intr = 1'b0;

    // Reset while in EXEC, with ack still asserted
    imem_ack = 1'b1;
    tick();
    chk("pre_rst_exec", {30'd0, state}, 32'd2);
    RST_N = 1'b0;
    tick();
    chk("midrst_pc", PC, 32'h0);
    chk("midrst_state", {30'd0, state}, 32'd0);
    chk("midrst_trap_taken", {31'd0, trap_taken}, 32'd0);
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("midrst_epc", trap_epc, 32'd0);
    tick();
    chk("midrst_ack_ignored", {30'd0, state}, 32'd0);
    imem_ack = 1'b0;
    RST_N    = 1'b1;
    tick();
    chk("post_rst_fetch", {30'd0, state}, 32'd1);

    // Wrap around 2^32
    jalr = 32'hFFFF_FFFC;
    run_instr(3'd3, 1'b0, 1'b0);
    chk("wrap_pc_top", PC, 32'hFFFF_FFFC);
    chk("wrap_plus4_top", PC_plus4, 32'h0);
    run_instr(3'd0, 1'b0, 1'b0);
    chk("wrap_pc", PC, 32'h0);
    chk("wrap_plus4", PC_plus4, 32'h4);
    chk("wrap_no_trap", {31'd0, trap_taken}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
